// File: rtl/edge_event_if.sv
// Event stream between the edge monitor (master) and its consumer (slave).
// The master presents the head of its event FIFO; the slave pops it with ev_ready.
interface edge_event_if #(
    parameter int TSW = 8
);
    logic           ev_valid;
    logic           ev_ready;
    logic           ev_edge;
    logic [TSW-1:0] ev_time;

    modport master (
        output ev_valid,
        output ev_edge,
        output ev_time,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_edge,
        input  ev_time,
        output ev_ready
    );
endinterface

// File: rtl/edge_event_monitor.sv
// Edge event monitor: synchronizes an asynchronous input, detects rising and
// falling edges, timestamps each edge into a small FIFO and keeps saturating
// per-direction edge counters plus a sticky overflow flag.
// Optional feature: define EDGE_MON_GLITCH_FILTER_EN to require the synchronized
// input to hold a new value for 3 consecutive cycles before it is accepted.
module edge_event_monitor #(
    parameter int DEPTH = 4,
    parameter int TSW   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                x_in,
    input  logic                clr,
    output logic                level,
    edge_event_if.master        ev,
    output logic [7:0]          pos_cnt,
    output logic [7:0]          neg_cnt,
    output logic                overflow
);

    localparam int AW = $clog2(DEPTH);

    logic           sync1;
    logic           sync2;
    logic           prev;
    logic           rise;
    logic           fall;
    logic           det;
    logic [TSW-1:0] ts;

    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [TSW:0]   mem [DEPTH];
    logic [TSW:0]   head;
    logic           empty;
    logic           full;
    logic           valid;
    logic           push;
    logic           pop;

    // Two-flop synchronizer for the asynchronous input.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= x_in;
            sync2 <= sync1;
        end
    end

`ifdef EDGE_MON_GLITCH_FILTER_EN
    logic filt;
    logic seen;

    // Accept a new level only once it has been seen in sync2 for two cycles and
    // is already confirmed for a third in sync1; shorter pulses never reach level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= 1'b0;
            seen <= 1'b0;
        end else if (sync2 == filt) begin
            seen <= 1'b0;
        end else if (seen && (sync1 == sync2)) begin
            filt <= sync2;
            seen <= 1'b0;
        end else begin
            seen <= 1'b1;
        end
    end

    assign level = filt;
`else
    assign level = sync2;
`endif

    assign rise = level & ~prev;
    assign fall = ~level & prev;
    assign det  = rise | fall;

    // Previous accepted level; an edge is pushed on the same clock that updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    // Free-running timestamp, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + TSW'(1);
        end
    end

    // FIFO status from extended pointers: the extra MSB separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid = ~empty;
    assign pop   = valid & ev.ev_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push  = det & (~full | pop);

    // FIFO pointer update; pointers reset so a reset discards every queued event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Event storage write: {edge type, timestamp}.
    // NOTE: the storage array has no reset; validity lives entirely in the
    // pointers, and the head outputs are gated so stale contents never show.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {level, ts};
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

    // Head presentation; zero whenever nothing is queued (including reset).
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        ev.ev_valid = valid;
        ev.ev_edge  = 1'b0;
        ev.ev_time  = '0;
        if (valid) begin
            ev.ev_edge = head[TSW];
            ev.ev_time = head[TSW-1:0];
        end
    end

    // Saturating edge counters; clear has priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt <= '0;
            neg_cnt <= '0;
        end else if (clr) begin
            pos_cnt <= '0;
            neg_cnt <= '0;
        end else begin
            if (rise && (pos_cnt != 8'hFF)) pos_cnt <= pos_cnt + 8'd1;
            if (fall && (neg_cnt != 8'hFF)) neg_cnt <= neg_cnt + 8'd1;
        end
    end

    // Sticky overflow: an edge arrived while full and nothing was popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clr) begin
            overflow <= 1'b0;
        end else if (det && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_edge_event_monitor.sv
// Self-checking bench for edge_event_monitor with a scoreboard of expected events.
// Build with EDGE_MON_GLITCH_FILTER_EN defined to exercise the glitch filter.
module tb_edge_event_monitor;

    localparam int DEPTH = 4;
    localparam int TSW   = 8;
`ifdef EDGE_MON_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic           rising;
        logic [TSW-1:0] t;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       x_in  = 1'b0;
    logic       clr   = 1'b0;
    logic       level;
    logic [7:0] pos_cnt;
    logic [7:0] neg_cnt;
    logic       overflow;

    edge_event_if #(.TSW(TSW)) ev_bus ();

    edge_event_monitor #(.DEPTH(DEPTH), .TSW(TSW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x_in     (x_in),
        .clr      (clr),
        .level    (level),
        .ev       (ev_bus),
        .pos_cnt  (pos_cnt),
        .neg_cnt  (neg_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; matches the timestamp a correct DUT pushes.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    ev_t sb[$];
    int  total    = 0;
    int  bad      = 0;
    int  exp_pos  = 0;
    int  exp_neg  = 0;
    int  seen_cnt = 0;

    // Pops and compares every consumed event against the scoreboard.
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ev_bus.ev_valid && ev_bus.ev_ready) begin
                total++;
                seen_cnt++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event got edge=%0b time=%0d want none",
                             ev_bus.ev_edge, ev_bus.ev_time);
                end else begin
                    e = sb.pop_front();
                    if ({ev_bus.ev_edge, ev_bus.ev_time} !== e) begin
                        bad++;
                        $display("FAIL event_content got edge=%0b time=%0d want edge=%0b time=%0d",
                                 ev_bus.ev_edge, ev_bus.ev_time, e.rising, e.t);
                    end
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Change x_in one cycle later; record the expected event if it will be queued.
    task automatic drive_x(input logic v, input bit kept, output int t_set);
        ev_t e;
        @(posedge clk);
        #1;
        x_in  = v;
        t_set = cyc;
        if (v) exp_pos = (exp_pos < 255) ? exp_pos + 1 : 255;
        else   exp_neg = (exp_neg < 255) ? exp_neg + 1 : 255;
        if (kept) begin
            e.rising = v;
            e.t      = TSW'(cyc + LAT);
            sb.push_back(e);
        end
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_pos = 0;
        exp_neg = 0;
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        ev_bus.ev_ready = 1'b1;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !ev_bus.ev_valid) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL drain_timeout got pending=%0d valid=%0b want 0 0",
                     sb.size(), ev_bus.ev_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        total++; if (ev_bus.ev_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %0b want 0", ev_bus.ev_valid); end
        total++; if (ev_bus.ev_edge !== 1'b0) begin bad++; $display("FAIL rst_edge got %0b want 0", ev_bus.ev_edge); end
        total++; if (ev_bus.ev_time !== 8'd0) begin bad++; $display("FAIL rst_time got %0d want 0", ev_bus.ev_time); end
        total++; if (level !== 1'b0) begin bad++; $display("FAIL rst_level got %0b want 0", level); end
        total++; if (pos_cnt !== 8'd0 || neg_cnt !== 8'd0) begin bad++; $display("FAIL rst_counts got %0d/%0d want 0/0", pos_cnt, neg_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got %0b want 0", overflow); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_edge();
        int t_set;
        int n     = 0;
        int first = -1;
        logic [TSW-1:0] t_seen = '0;
        logic e_seen = 1'b0;
        ev_bus.ev_ready = 1'b1;
        while (cyc < 9) wait_cycles(1);
        drive_x(1'b1, 1'b1, t_set);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ev_bus.ev_valid) begin
                if (n == 0) begin
                    first  = cyc;
                    t_seen = ev_bus.ev_time;
                    e_seen = ev_bus.ev_edge;
                end
                n++;
            end
        end
        total++; if (t_set != 10) begin bad++; $display("FAIL single_setup got cyc=%0d want 10", t_set); end
        total++; if (n != 1) begin bad++; $display("FAIL single_valid_cycles got %0d want 1", n); end
        total++; if (first != 10 + LAT + 1) begin bad++; $display("FAIL single_latency got cyc=%0d want %0d", first, 10 + LAT + 1); end
        total++; if (e_seen !== 1'b1 || t_seen !== TSW'(10 + LAT)) begin bad++; $display("FAIL single_head got edge=%0b time=%0d want 1 %0d", e_seen, t_seen, 10 + LAT); end
        total++; if (pos_cnt !== 8'd1 || neg_cnt !== 8'd0) begin bad++; $display("FAIL single_counts got %0d/%0d want 1/0", pos_cnt, neg_cnt); end
        total++; if (level !== 1'b1) begin bad++; $display("FAIL single_level got %0b want 1", level); end
        drive_x(1'b0, 1'b1, t_set);
        drain(50);
    endtask

    task automatic test_overflow();
        int t_set;
        pulse_clr();
        ev_bus.ev_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_x(~x_in, i < DEPTH, t_set);
            wait_cycles(3);
        end
        wait_cycles(LAT + 3);
        total++; if (ev_bus.ev_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got %0b want 1", ev_bus.ev_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        total++; if (int'(pos_cnt) + int'(neg_cnt) != 5) begin bad++; $display("FAIL ovf_total got %0d want 5", int'(pos_cnt) + int'(neg_cnt)); end
        total++; if (pos_cnt !== 8'(exp_pos) || neg_cnt !== 8'(exp_neg)) begin bad++; $display("FAIL ovf_counts got %0d/%0d want %0d/%0d", pos_cnt, neg_cnt, exp_pos, exp_neg); end
        drain(50);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got %0b want 1", overflow); end
        pulse_clr();
        total++; if (overflow !== 1'b0 || pos_cnt !== 8'd0 || neg_cnt !== 8'd0) begin bad++; $display("FAIL ovf_clr got ovf=%0b cnt=%0d/%0d want 0 0/0", overflow, pos_cnt, neg_cnt); end
    endtask

    task automatic test_full_pop_push();
        int t_set;
        ev_bus.ev_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_x(~x_in, 1'b1, t_set);
            wait_cycles(3);
        end
        wait_cycles(LAT + 3);
        total++; if (ev_bus.ev_valid !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL full_pre got valid=%0b ovf=%0b want 1 0", ev_bus.ev_valid, overflow); end
        drive_x(~x_in, 1'b1, t_set);
        while (cyc < t_set + LAT) wait_cycles(1);
        ev_bus.ev_ready = 1'b1;
        wait_cycles(1);
        ev_bus.ev_ready = 1'b0;
        wait_cycles(2);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_poppush_ovf got %0b want 0", overflow); end
        total++; if (sb.size() != DEPTH) begin bad++; $display("FAIL full_popush_pending got %0d want %0d", sb.size(), DEPTH); end
        drain(50);
        total++; if (overflow !== 1'b0 || pos_cnt !== 8'(exp_pos) || neg_cnt !== 8'(exp_neg)) begin bad++; $display("FAIL full_post got ovf=%0b cnt=%0d/%0d want 0 %0d/%0d", overflow, pos_cnt, neg_cnt, exp_pos, exp_neg); end
    endtask

    task automatic test_saturation();
        int t_set;
        int k = 0;
        ev_t head;
        pulse_clr();
        ev_bus.ev_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive_x(1'b1, k < DEPTH, t_set); k++;
            wait_cycles(3);
            drive_x(1'b0, k < DEPTH, t_set); k++;
            wait_cycles(3);
        end
        wait_cycles(LAT + 3);
        head = sb[0];
        total++; if (pos_cnt !== 8'(exp_pos) || exp_pos != 255) begin bad++; $display("FAIL sat_pos got %0d want 255", pos_cnt); end
        total++; if (neg_cnt !== 8'd255) begin bad++; $display("FAIL sat_neg got %0d want 255", neg_cnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL sat_ovf got %0b want 1", overflow); end
        pulse_clr();
        total++; if (pos_cnt !== 8'd0 || neg_cnt !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL sat_clr got %0d/%0d ovf=%0b want 0/0 0", pos_cnt, neg_cnt, overflow); end
        total++; if (ev_bus.ev_valid !== 1'b1 || {ev_bus.ev_edge, ev_bus.ev_time} !== head) begin bad++; $display("FAIL sat_head_kept got valid=%0b edge=%0b time=%0d want 1 %0b %0d", ev_bus.ev_valid, ev_bus.ev_edge, ev_bus.ev_time, head.rising, head.t); end
        seen_cnt = 0;
        drain(50);
        total++; if (seen_cnt != DEPTH) begin bad++; $display("FAIL sat_drained got %0d want %0d", seen_cnt, DEPTH); end
    endtask

    task automatic test_glitch();
        int t_set;
        int n = 0;
        ev_bus.ev_ready = 1'b1;
`ifdef EDGE_MON_GLITCH_FILTER_EN
        @(posedge clk);
        #1;
        x_in = 1'b1;
        wait_cycles(2);
        x_in = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ev_bus.ev_valid) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL filt_short_pulse got %0d valid cycles want 0", n); end
        total++; if (pos_cnt !== 8'(exp_pos) || level !== 1'b0) begin bad++; $display("FAIL filt_short_count got %0d lvl=%0b want %0d 0", pos_cnt, level, exp_pos); end
        drive_x(1'b1, 1'b1, t_set);
        wait_cycles(2);
        drive_x(1'b0, 1'b1, t_set);
`else
        drive_x(1'b1, 1'b1, t_set);
        wait_cycles(1);
        drive_x(1'b0, 1'b1, t_set);
`endif
        drain(50);
        total++; if (pos_cnt !== 8'(exp_pos) || neg_cnt !== 8'(exp_neg)) begin bad++; $display("FAIL pulse_counts got %0d/%0d want %0d/%0d", pos_cnt, neg_cnt, exp_pos, exp_neg); end
    endtask

    task automatic test_reset_mid();
        int t_set;
        ev_t e;
        ev_bus.ev_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_x(~x_in, 1'b1, t_set);
            wait_cycles(3);
        end
        wait_cycles(LAT + 3);
        total++; if (ev_bus.ev_valid !== 1'b1 || x_in !== 1'b1) begin bad++; $display("FAIL mid_pre got valid=%0b x=%0b want 1 1", ev_bus.ev_valid, x_in); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (ev_bus.ev_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got %0b want 0", ev_bus.ev_valid); end
        total++; if (pos_cnt !== 8'd0 || neg_cnt !== 8'd0 || overflow !== 1'b0) begin bad++; $display("FAIL mid_counts got %0d/%0d ovf=%0b want 0/0 0", pos_cnt, neg_cnt, overflow); end
        total++; if (level !== 1'b0 || ev_bus.ev_time !== 8'd0 || ev_bus.ev_edge !== 1'b0) begin bad++; $display("FAIL mid_outputs got lvl=%0b time=%0d edge=%0b want 0 0 0", level, ev_bus.ev_time, ev_bus.ev_edge); end
        sb.delete();
        exp_pos = 1;
        exp_neg = 0;
        e.rising = 1'b1;
        e.t      = TSW'(LAT);
        sb.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ev_bus.ev_ready = 1'b1;
        seen_cnt = 0;
        drain(50);
        wait_cycles(10);
        total++; if (seen_cnt != 1) begin bad++; $display("FAIL mid_one_event got %0d want 1", seen_cnt); end
        total++; if (pos_cnt !== 8'(exp_pos) || neg_cnt !== 8'(exp_neg)) begin bad++; $display("FAIL mid_post_counts got %0d/%0d want 1/0", pos_cnt, neg_cnt); end
    endtask

    initial begin
        ev_bus.ev_ready = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_edge();
        test_overflow();
        test_full_pop_push();
        test_saturation();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/edge_event_monitor.md
EDGE_EVENT_MONITOR -- requirements
Module: edge_event_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO entries (power of 2, >= 2).
REQ-002 SHALL have parameter TSW, default 8, timestamp width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port x_in  input  1  monitored signal, asynchronous to clk.
REQ-006 SHALL have port clr  input  1  synchronous clear of counters and overflow flag.
REQ-007 SHALL have port level  output  1  current accepted (synchronized, optionally filtered) level of x_in.
REQ-008 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts head event.
REQ-010 SHALL have port ev_edge  output  1  head event type: 1 = posedge, 0 = negedge.
REQ-011 SHALL have port ev_time  output  TSW  timestamp of head event.
REQ-012 SHALL have ports pos_cnt, neg_cnt  output  8 each  posedge / negedge totals.
REQ-013 SHALL have port overflow  output  1  sticky: an event was dropped.

Function
REQ-014 SHALL pass x_in through a 2-flop synchronizer; the accepted level is the second stage (or the filter output per REQ-029).
REQ-015 SHALL hold the previous accepted level in a register; posedge = prev 0, level 1; negedge = prev 1, level 0.
REQ-016 SHALL push one event at the clock edge that updates prev, i.e. 3 rising edges after the first edge sampling a new x_in level; ev_valid rises after that edge if the FIFO was empty.
REQ-017 SHALL run a free-running TSW-bit timestamp counter, incrementing every cycle and wrapping from all-ones to 0; the pushed ev_time is the counter value in the push cycle.
REQ-018 SHALL pop the head when ev_valid && ev_ready; ev_edge/ev_time SHALL remain stable while ev_valid && !ev_ready.
REQ-019 SHALL NOT bypass: an event pushed into an empty FIFO becomes visible the cycle after the push.
REQ-020 SHALL, when full with no pop in the same cycle, drop the new event and set overflow.
REQ-021 SHALL, when full with a pop in the same cycle, accept the push (no drop, no overflow).
REQ-022 SHALL increment pos_cnt/neg_cnt on every detected edge, including dropped ones, saturating at 255.
REQ-023 SHALL, on clr, set pos_cnt, neg_cnt and overflow to 0 at the next edge; clr wins over a simultaneous increment or overflow set; clr SHALL NOT flush the FIFO or stop a simultaneous push.

Reset
REQ-024 SHALL, while rst_n is low, clear synchronizer stages, prev, level, filter state, timestamp, FIFO pointers, counters and overflow to 0.
REQ-025 SHALL hold ev_valid at 0 during reset; ev_edge and ev_time SHALL be 0.
REQ-026 SHALL discard all queued events when reset asserts mid-operation.
REQ-027 SHALL treat the post-reset level as 0, so x_in held high through reset yields exactly one posedge event.

Configuration
REQ-028 SHALL honour macro EDGE_MON_GLITCH_FILTER_EN.
REQ-029 SHALL, with EDGE_MON_GLITCH_FILTER_EN defined, change the accepted level only after the synchronized value has differed from it for 3 consecutive cycles (+2 cycles latency; shorter pulses ignored, no event, no count).
REQ-030 SHALL, without EDGE_MON_GLITCH_FILTER_EN, use the second synchronizer stage directly with the REQ-016 latency.

Verification
REQ-031 SHALL cover: filter off, x_in 0->1 at cycle 10, ev_ready=1 -> ev_valid high 1 cycle with ev_edge=1, ev_time=12, pos_cnt=1.
REQ-032 SHALL cover: ev_ready=0, 5 toggles spaced 4 cycles, DEPTH=4 -> 4 events queued, overflow=1, pos_cnt+neg_cnt=5; draining yields events in order.
REQ-033 SHALL cover: FIFO full, pop and push in the same cycle -> push accepted, overflow stays 0.
REQ-034 SHALL cover: 300 posedges, clr pulsed afterwards -> pos_cnt saturates at 255, then 0 after clr, queued FIFO entries unchanged.
REQ-035 SHALL cover: filter on, 2-cycle high pulse -> no event; 3-cycle pulse -> posedge then negedge event.
REQ-036 SHALL cover: rst_n low with 3 events queued -> ev_valid 0 immediately (asynchronously), counters 0; x_in high across reset -> exactly one posedge after release.
